// File: rtl/bit_extract_seq.sv
// Multi-cycle bit-extract ("pext") unit: gathers the opA bits selected by the set bits
// of opB and packs them from result bit 0 upward, BITS_PER_CYCLE mask bits per cycle.
module bit_extract_seq #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result,
  output logic [6:0]      flags
);

  localparam int wpWidth = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  typedef struct packed {
    logic divideByZero;
    logic carryOut;
    logic overflow;
    logic evenParity;
    logic oddParity;
    logic sign;
    logic zero;
  } flagsT;

  if (XLEN % BITS_PER_CYCLE != 0) begin : gBadChunkWidth
    $error("BITS_PER_CYCLE must divide XLEN");
  end

  function automatic flagsT makeFlags(input logic [XLEN-1:0] value);
    flagsT f;
    f            = '0;
    f.zero       = (value == '0);
    f.sign       = value[XLEN-1];
    f.oddParity  = ^value;
    f.evenParity = ~^value;
    return f;
  endfunction

  stateT              state;
  stateT              nextState;
  logic [XLEN-1:0]    dataRem;
  logic [XLEN-1:0]    maskRem;
  logic [XLEN-1:0]    acc;
  logic [wpWidth-1:0] wp;
  logic [XLEN-1:0]    chunkAcc;
  logic [wpWidth-1:0] chunkWp;
  logic [XLEN-1:0]    resultReg;
  flagsT              flagsReg;
  logic               accept;
  logic               lastChunk;

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);
  assign accept   = inValid && inReady;
  assign result   = resultReg;
  assign flags    = flagsReg;

  // Operands shift down one chunk per RUN cycle, so the current chunk is always the
  // low bits; nothing left above it in the mask means this is the final chunk.
  assign lastChunk = ((maskRem >> BITS_PER_CYCLE) == '0);

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so each path has a defined value and no latch is inferred.
  always_comb begin
    chunkAcc = acc;
    chunkWp  = wp;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (maskRem[i]) begin
        chunkAcc[chunkWp[wpWidth-2:0]] = dataRem[i];
        chunkWp                        = chunkWp + wpWidth'(1);
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (accept) nextState = (opB == '0) ? DONE : RUN;
      RUN:  if (lastChunk) nextState = DONE;
      DONE: if (outReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples the
  // pre-edge values and update order within the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataRem   <= '0;
      maskRem   <= '0;
      acc       <= '0;
      wp        <= '0;
      resultReg <= '0;
      flagsReg  <= makeFlags('0);
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dataRem <= opA;
            maskRem <= opB;
            acc     <= '0;
            wp      <= '0;
            if (opB == '0) begin
              resultReg <= '0;
              flagsReg  <= makeFlags('0);
            end
          end
        end
        RUN: begin
          dataRem <= dataRem >> BITS_PER_CYCLE;
          maskRem <= maskRem >> BITS_PER_CYCLE;
          acc     <= chunkAcc;
          wp      <= chunkWp;
          if (lastChunk) begin
            resultReg <= chunkAcc;
            flagsReg  <= makeFlags(chunkAcc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_extract_seq.sv
// Self-checking bench for bit_extract_seq: directed corner cases plus random operations,
// compared against a bit-by-bit extract model and a latency formula derived from the mask msb.
module tb_bit_extract_seq;

  localparam int XLEN = 32;
  localparam int B    = 4;
  localparam logic [6:0] RESET_FLAGS = 7'b0001001;

  logic            clk = 1'b0;
  logic            rst;
  logic            inValid;
  logic            inReady;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] result;
  logic [6:0]      flags;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] lastResult;
  logic [6:0]      lastFlags;

  always #5 clk = ~clk;

  bit_extract_seq #(.XLEN(XLEN), .BITS_PER_CYCLE(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .opA      (opA),
    .opB      (opB),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .flags    (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] refExtract(input logic [XLEN-1:0] a, input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    int j;
    r = '0;
    j = 0;
    for (int i = 0; i < XLEN; i++) begin
      if (m[i]) begin
        r[j] = a[i];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] refFlags(input logic [XLEN-1:0] r);
    int ones;
    ones = $countones(r);
    return {3'b000, 1'((ones % 2) == 0), 1'((ones % 2) == 1), r[XLEN-1], 1'(r == '0)};
  endfunction

  // Cycles from the accept edge until outValid is seen: 1 + number of RUN chunks.
  function automatic int refLatency(input logic [XLEN-1:0] m);
    int msb;
    if (m == '0) return 1;
    msb = 0;
    for (int i = 0; i < XLEN; i++) if (m[i]) msb = i;
    return 1 + msb / B + 1;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
  task automatic startOp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    inValid = 1'b1;
    opA     = a;
    opB     = b;
    check("accept_inReady", 32'(inReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    inValid  = 1'($urandom_range(0, 1));
    opA      = $urandom;
    opB      = $urandom;
    outReady = 1'b0;
  endtask

  task automatic waitResult(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] expResult;
    logic [6:0]      expFlags;
    int lat;
    expResult = refExtract(a, b);
    expFlags  = refFlags(expResult);
    lat = 1;
    while (!outValid && lat <= XLEN / B + 2) begin
      check("busy_inReady", 32'(inReady), 32'd0);
      check("run_result_held", result, lastResult);
      outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    outReady = 1'b0;
    check("latency", 32'(lat), 32'(refLatency(b)));
    check("outValid", 32'(outValid), 32'd1);
    check("result", result, expResult);
    check("flags", 32'(flags), 32'(expFlags));
    check("done_inReady", 32'(inReady), 32'd0);
    lastResult = expResult;
    lastFlags  = expFlags;
  endtask

  task automatic holdAndRelease(input int hold, input bit nextValid,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    inValid = nextValid;
    opA     = a;
    opB     = b;
    repeat (hold) begin
      @(negedge clk);
      check("hold_outValid", 32'(outValid), 32'd1);
      check("hold_result", result, lastResult);
      check("hold_flags", 32'(flags), 32'(lastFlags));
      check("hold_inReady", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    check("bubble_outValid", 32'(outValid), 32'd0);
    check("bubble_inReady", 32'(inReady), 32'd1);
    check("idle_result_held", result, lastResult);
  endtask

  task automatic doOp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int hold);
    startOp(a, b);
    waitResult(a, b);
    holdAndRelease(hold, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    logic [XLEN-1:0] ones;
    bit rise;

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    opA      = '0;
    opB      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_inReady", 32'(inReady), 32'd1);
    check("reset_outValid", 32'(outValid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'(RESET_FLAGS));
    rst        = 1'b0;
    lastResult = '0;
    lastFlags  = RESET_FLAGS;

    // Directed corner cases
    doOp(32'hF0F0_1234, 32'h0000_FF00, 0);
    doOp(32'h8000_0001, 32'hFFFF_FFFF, 1);
    doOp(32'h8000_0000, 32'h8000_0000, 0);
    doOp(32'h7FFF_FFFF, 32'h8000_0000, 0);
    doOp(32'hDEAD_BEEF, 32'h0000_0000, 2);

    // Backpressure with a second request waiting behind the pending result
    startOp(32'hF0F0_1234, 32'h0000_FF00);
    waitResult(32'hF0F0_1234, 32'h0000_FF00);
    holdAndRelease(5, 1'b1, 32'hFFFF_FFFF, 32'h0000_000F);
    startOp(32'hFFFF_FFFF, 32'h0000_000F);
    waitResult(32'hFFFF_FFFF, 32'h0000_000F);
    holdAndRelease(0, 1'b0, '0, '0);

    // Reset in the middle of a long operation
    startOp(32'h1234_5678, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_inReady", 32'(inReady), 32'd1);
    check("midrun_reset_outValid", 32'(outValid), 32'd0);
    check("midrun_reset_result", result, 32'd0);
    check("midrun_reset_flags", 32'(flags), 32'(RESET_FLAGS));
    rise = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outValid) rise = 1'b1;
    end
    check("midrun_no_pulse", 32'(rise), 32'd0);
    lastResult = '0;
    lastFlags  = RESET_FLAGS;
    doOp(32'hCAFE_F00D, 32'h00F0_0F0F, 0);

    // Random operations with assorted mask shapes
    for (int n = 0; n < 40; n++) begin
      ra   = $urandom;
      ones = 32'hFFFF_FFFF;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = ones;
        2:       rb = $urandom;
        3:       rb = $urandom & (ones >> $urandom_range(1, 31));
        default: rb = 32'd1 << $urandom_range(0, 31);
      endcase
      doOp(ra, rb, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
